ahb_slave_interface: RTL and testbench

AHB-side front end of the AHB-to-APB bridge. It sits directly downstream of the AHB master interface, and samples and pipelines the master's address, control and write data. It decodes transfer validity and the peripheral select, and hands all of this to the bridge APB controller FSM. It returns read data, HREADYOUT and HRESP to the master, including a two-cycle ERROR response for unmapped addresses.

---
 rtl/ahb_apb_pkg.sv | 37 +++
 rtl/ahb_addr_decode.sv | 50 +++++
 rtl/ahb_slave_interface.sv | 171 +++++++++++++++++
 tb/tb_ahb_slave_interface.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_apb_pkg
// Shared definitions for the AHB-to-APB bridge: AHB transfer-type and
// response encodings, default address-window constants and the state type
// of the AHB-side error-response FSM.
// Ports: none (package).
// Configuration macro used by the bridge: AHB_SLV_ERR_RESP_EN.
// ----------------------------------------------------------------------------
package ahb_apb_pkg;

    // AHB HTRANS encodings
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // AHB HRESP encodings (only OKAY and ERROR are produced by this bridge)
    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    // Default address window: slot k covers
    // [AHB_BASE_ADDR + k*AHB_SLOT_SIZE, AHB_BASE_ADDR + (k+1)*AHB_SLOT_SIZE)
    localparam logic [31:0] AHB_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] AHB_SLOT_SIZE = 32'h0400_0000;

    // Two-cycle ERROR response sequencer
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } resp_state_e;

endpackage

// File: rtl/ahb_addr_decode.sv
// ----------------------------------------------------------------------------
// ahb_addr_decode
// Purely combinational address decoder for the bridge window.
// Ports:
//   haddr_i     in  32          AHB address of the current address phase
//   mapped_o    out 1           address lies inside the bridge window
//   tempselx_o  out NUM_SLAVES  one-hot slot select, all zeros when unmapped
// Configuration macro used by the bridge: AHB_SLV_ERR_RESP_EN (not used here).
// ----------------------------------------------------------------------------
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = AHB_BASE_ADDR,
    parameter logic [31:0] SLOT_SIZE  = AHB_SLOT_SIZE,
    parameter int          NUM_SLAVES = 3
) (
    input  logic [31:0]           haddr_i,
    output logic                  mapped_o,
    output logic [NUM_SLAVES-1:0] tempselx_o
);

    // All bounds are carried in 33 bits so a window that ends exactly at
    // 4 GiB (or a misconfigured one that would run past it) cannot wrap.
    localparam logic [32:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [32:0] SLOT_SZ = {1'b0, SLOT_SIZE};
    localparam logic [32:0] WIN_HI  = WIN_LO + (33'(NUM_SLAVES) * SLOT_SZ);

    logic [32:0] addrExt;
    logic [32:0] slotLo;
    logic [32:0] slotHi;

    assign addrExt = {1'b0, haddr_i};

    // Window hit plus a per-slot range compare; slot ranges are disjoint so
    // at most one select bit can be set, and none outside the window.
    always_comb begin
        mapped_o   = (addrExt >= WIN_LO) && (addrExt < WIN_HI);
        tempselx_o = '0;
        slotLo     = WIN_LO;
        slotHi     = WIN_LO;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            slotLo = WIN_LO + (33'(k) * SLOT_SZ);
            slotHi = slotLo + SLOT_SZ;
            if ((addrExt >= slotLo) && (addrExt < slotHi)) begin
                tempselx_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_interface.sv
// ----------------------------------------------------------------------------
// ahb_slave_interface
// AHB-side front end of the AHB-to-APB bridge. Pipelines address, write data
// and direction for the APB controller FSM, decodes transfer validity and the
// peripheral select, and returns read data, HREADYOUT and HRESP.
// Optional two-cycle ERROR response for unmapped addresses is built only when
// the macro AHB_SLV_ERR_RESP_EN is defined; otherwise unmapped transfers are
// simply not marked valid and get an OKAY response.
// Ports:
//   hclk, hresetn                clock, synchronous active-high reset
//   hwrite, hreadyin, htrans     AHB control from the master
//   haddr, hwdata                AHB address / write data from the master
//   prdata, bridge_ready         read data and ready from the APB controller
//   valid, tempselx              decoded transfer valid / one-hot slot select
//   haddr_1/2, hwdata_1/2        address and write data delayed 1 / 2 stages
//   hwrite_reg, hwrite_reg1      direction delayed 1 / 2 stages
//   hrdata, hreadyout, hresp     response to the master
// ----------------------------------------------------------------------------
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = AHB_BASE_ADDR,
    parameter logic [31:0] SLOT_SIZE  = AHB_SLOT_SIZE,
    parameter int          NUM_SLAVES = 3
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hwrite,
    input  logic                  hreadyin,
    input  logic [1:0]            htrans,
    input  logic [31:0]           haddr,
    input  logic [31:0]           hwdata,
    input  logic [31:0]           prdata,
    input  logic                  bridge_ready,
    output logic                  valid,
    output logic [NUM_SLAVES-1:0] tempselx,
    output logic [31:0]           haddr_1,
    output logic [31:0]           haddr_2,
    output logic [31:0]           hwdata_1,
    output logic [31:0]           hwdata_2,
    output logic                  hwrite_reg,
    output logic                  hwrite_reg1,
    output logic [31:0]           hrdata,
    output logic                  hreadyout,
    output logic [1:0]            hresp
);

    logic        addrMapped;
    logic        transActive;
    logic        stateIdle;

    logic [31:0] haddr1_q;
    logic [31:0] haddr2_q;
    logic [31:0] hwdata1_q;
    logic [31:0] hwdata2_q;
    logic        hwrite1_q;
    logic        hwrite2_q;

    ahb_addr_decode #(
        .BASE_ADDR  (BASE_ADDR),
        .SLOT_SIZE  (SLOT_SIZE),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_addr_decode (
        .haddr_i    (haddr),
        .mapped_o   (addrMapped),
        .tempselx_o (tempselx)
    );

    assign transActive = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

    // Address/data/direction pipeline. Write data trails its address by one
    // cycle on AHB, so hwdata_1 lines up with haddr_2. Everything freezes
    // while the master holds hreadyin low so the stages stay aligned.
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
        end else if (hreadyin) begin
            haddr1_q  <= haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite1_q <= hwrite;
            hwrite2_q <= hwrite1_q;
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    resp_state_e state_q;
    resp_state_e state_d;
    logic        errReady_q;
    logic        errReady_d;
    hresp_e      hresp_q;
    hresp_e      hresp_d;

    // Next-state logic of the ERROR sequencer. The response values are
    // computed for the state being entered so that they come out of flops.
    // Only NONSEQ/SEQ to an unmapped address starts the sequence; once
    // started it always runs ERR1 -> ERR2 -> IDLE regardless of inputs.
    always_comb begin
        state_d    = state_q;
        errReady_d = errReady_q;
        hresp_d    = hresp_q;
        case (state_q)
            ST_IDLE: begin
                if (hreadyin && transActive && !addrMapped) begin
                    state_d    = ST_ERR1;
                    errReady_d = 1'b0;
                    hresp_d    = HRESP_ERROR;
                end
            end
            ST_ERR1: begin
                state_d    = ST_ERR2;
                errReady_d = 1'b1;
                hresp_d    = HRESP_ERROR;
            end
            ST_ERR2: begin
                state_d    = ST_IDLE;
                errReady_d = 1'b1;
                hresp_d    = HRESP_OKAY;
            end
            default: begin
                state_d    = ST_IDLE;
                errReady_d = 1'b1;
                hresp_d    = HRESP_OKAY;
            end
        endcase
    end

    // State and registered response flops.
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            state_q    <= ST_IDLE;
            errReady_q <= 1'b1;
            hresp_q    <= HRESP_OKAY;
        end else begin
            state_q    <= state_d;
            errReady_q <= errReady_d;
            hresp_q    <= hresp_d;
        end
    end

    assign stateIdle = (state_q == ST_IDLE);

    // In IDLE the APB side controls wait states; during the error sequence
    // the registered value wins. Reset overrides immediately, not a cycle late.
    assign hreadyout = hresetn   ? 1'b1 :
                       stateIdle ? bridge_ready :
                                   errReady_q;
    assign hresp     = hresetn ? HRESP_OKAY : hresp_q;
`else
    assign stateIdle = 1'b1;
    assign hreadyout = hresetn ? 1'b1 : bridge_ready;
    assign hresp     = HRESP_OKAY;
`endif

    assign valid = hreadyin & transActive & addrMapped & stateIdle & ~hresetn;

    assign haddr_1     = haddr1_q;
    assign haddr_2     = haddr2_q;
    assign hwdata_1    = hwdata1_q;
    assign hwdata_2    = hwdata2_q;
    assign hwrite_reg  = hwrite1_q;
    assign hwrite_reg1 = hwrite2_q;
    assign hrdata      = prdata;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_interface
// Self-checking bench for ahb_slave_interface. Keeps a behavioural reference
// model (window arithmetic, last-two-captured history, error-cycle counter)
// and compares it and directed constants against the DUT.
// Honours AHB_SLV_ERR_RESP_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_ahb_slave_interface;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SLOT = 32'h0400_0000;
    localparam int          NS   = 3;

`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          hclk;
    logic          hresetn;
    logic          hwrite;
    logic          hreadyin;
    logic [1:0]    htrans;
    logic [31:0]   haddr;
    logic [31:0]   hwdata;
    logic [31:0]   prdata;
    logic          bridge_ready;
    logic          valid;
    logic [NS-1:0] tempselx;
    logic [31:0]   haddr_1;
    logic [31:0]   haddr_2;
    logic [31:0]   hwdata_1;
    logic [31:0]   hwdata_2;
    logic          hwrite_reg;
    logic          hwrite_reg1;
    logic [31:0]   hrdata;
    logic          hreadyout;
    logic [1:0]    hresp;

    int checks = 0;
    int errors = 0;

    // Reference model state: the two most recently captured transfers and
    // how many error-response cycles are still outstanding (0 = none,
    // 1 = first ERROR cycle, 2 = second ERROR cycle).
    logic [31:0] mA1 = '0;
    logic [31:0] mA2 = '0;
    logic [31:0] mW1 = '0;
    logic [31:0] mW2 = '0;
    logic        mR1 = 1'b0;
    logic        mR2 = 1'b0;
    int          errPhase = 0;

    ahb_slave_interface dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .hwrite       (hwrite),
        .hreadyin     (hreadyin),
        .htrans       (htrans),
        .haddr        (haddr),
        .hwdata       (hwdata),
        .prdata       (prdata),
        .bridge_ready (bridge_ready),
        .valid        (valid),
        .tempselx     (tempselx),
        .haddr_1      (haddr_1),
        .haddr_2      (haddr_2),
        .hwdata_1     (hwdata_1),
        .hwdata_2     (hwdata_2),
        .hwrite_reg   (hwrite_reg),
        .hwrite_reg1  (hwrite_reg1),
        .hrdata       (hrdata),
        .hreadyout    (hreadyout),
        .hresp        (hresp)
    );

    // 100 MHz-style free-running clock
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic bit isMapped(input logic [31:0] a);
        longint unsigned ua;
        ua = {32'h0, a};
        return (ua >= longint'(BASE)) && (ua < longint'(BASE) + NS * longint'(SLOT));
    endfunction

    function automatic logic [NS-1:0] expSel(input logic [31:0] a);
        logic [NS-1:0]   s;
        longint unsigned ua;
        int              idx;
        s  = '0;
        ua = {32'h0, a};
        if (isMapped(a)) begin
            idx    = int'((ua - longint'(BASE)) / longint'(SLOT));
            s[idx] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic expValid();
        return hreadyin && htrans[1] && isMapped(haddr) && (errPhase == 0) && !hresetn;
    endfunction

    function automatic logic expReady();
        if (hresetn)            return 1'b1;
        else if (errPhase == 1) return 1'b0;
        else if (errPhase == 2) return 1'b1;
        else                    return bridge_ready;
    endfunction

    function automatic logic [1:0] expResp();
        if (hresetn || errPhase == 0) return 2'b00;
        else                          return 2'b01;
    endfunction

    // One clock: model samples the same inputs the DUT sees on the rising
    // edge, then control returns at the falling edge for the next drive.
    task automatic cycle();
        @(posedge hclk);
        if (hresetn) begin
            mA1 = '0; mA2 = '0; mW1 = '0; mW2 = '0; mR1 = 1'b0; mR2 = 1'b0;
            errPhase = 0;
        end else begin
            if (hreadyin) begin
                mA2 = mA1; mA1 = haddr;
                mW2 = mW1; mW1 = hwdata;
                mR2 = mR1; mR1 = hwrite;
            end
            if (errPhase == 1)      errPhase = 2;
            else if (errPhase == 2) errPhase = 0;
            else if (ERR_EN && hreadyin && htrans[1] && !isMapped(haddr)) errPhase = 1;
        end
        @(negedge hclk);
    endtask

    task automatic test_reset();
        hresetn = 1'b1; hwrite = 1'b1; hreadyin = 1'b1; htrans = 2'b10;
        haddr = BASE; hwdata = $urandom; prdata = $urandom; bridge_ready = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", valid); end
        checks++;
        if (hreadyout !== 1'b1) begin errors++; $display("[TB] FAIL reset_hreadyout got %b expected 1", hreadyout); end
        checks++;
        if (hresp !== 2'b00) begin errors++; $display("[TB] FAIL reset_hresp got %b expected 00", hresp); end
        cycle();
        cycle();
        hresetn = 1'b0; htrans = 2'b00; bridge_ready = 1'b1; hwrite = 1'b0;
        #1;
        checks++;
        if ({haddr_1, haddr_2, hwdata_1, hwdata_2, hwrite_reg, hwrite_reg1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_pipeline got %h/%h/%h/%h/%b/%b expected all 0",
                     haddr_1, haddr_2, hwdata_1, hwdata_2, hwrite_reg, hwrite_reg1);
        end
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_resp got rdy=%b resp=%b valid=%b expected 1/00/0",
                     hreadyout, hresp, valid);
        end
    endtask

    task automatic test_single_write();
        haddr = 32'h8000_0000; htrans = 2'b10; hwrite = 1'b1; hreadyin = 1'b1;
        bridge_ready = 1'b1; hwdata = 32'hDEAD_0000;
        #1;
        checks++;
        if (valid !== 1'b1) begin errors++; $display("[TB] FAIL write_valid got %b expected 1", valid); end
        checks++;
        if (tempselx !== 3'b001) begin errors++; $display("[TB] FAIL write_sel got %b expected 001", tempselx); end
        cycle();
        htrans = 2'b00; haddr = 32'h1234_5678; hwrite = 1'b0; hwdata = 32'h32;
        #1;
        checks++;
        if (haddr_1 !== 32'h8000_0000) begin errors++; $display("[TB] FAIL write_haddr1 got %h expected 80000000", haddr_1); end
        checks++;
        if (hwrite_reg !== 1'b1) begin errors++; $display("[TB] FAIL write_hwrite_reg got %b expected 1", hwrite_reg); end
        cycle();
        #1;
        checks++;
        if (hwdata_1 !== 32'h32) begin errors++; $display("[TB] FAIL write_hwdata1 got %h expected 00000032", hwdata_1); end
        checks++;
        if (haddr_2 !== 32'h8000_0000) begin errors++; $display("[TB] FAIL write_haddr2 got %h expected 80000000", haddr_2); end
        checks++;
        if (hwrite_reg1 !== 1'b1) begin errors++; $display("[TB] FAIL write_hwrite_reg1 got %b expected 1", hwrite_reg1); end
    endtask

    task automatic test_burst_read();
        prdata = 32'hA5; hwrite = 1'b0; hreadyin = 1'b1; bridge_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            haddr  = 32'h8400_0000 + 32'(i);
            htrans = (i == 0) ? 2'b10 : 2'b11;
            #1;
            checks++;
            if (valid !== 1'b1 || tempselx !== 3'b010) begin
                errors++;
                $display("[TB] FAIL burst_valid_sel beat %0d got %b/%b expected 1/010", i, valid, tempselx);
            end
            checks++;
            if (hrdata !== 32'hA5) begin errors++; $display("[TB] FAIL burst_hrdata got %h expected 000000a5", hrdata); end
            cycle();
            #1;
            checks++;
            if (haddr_1 !== 32'h8400_0000 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL burst_haddr1 beat %0d got %h expected %h", i, haddr_1, 32'h8400_0000 + 32'(i));
            end
        end
        htrans = 2'b00;
    endtask

    task automatic test_wait_states();
        logic [31:0] a0;
        logic [31:0] a1;
        a0 = BASE + 32'h0800_0000 + ($urandom & 32'h00FF_FFFC);
        haddr = a0; htrans = 2'b10; hwrite = 1'b1; hreadyin = 1'b1; hwdata = $urandom;
        cycle();
        for (int i = 0; i < 2; i++) begin
            hreadyin = 1'b0; htrans = 2'b11; haddr = a0 + 32'd4; hwdata = $urandom; hwrite = 1'($urandom);
            #1;
            checks++;
            if (valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_valid got %b expected 0", valid); end
            cycle();
            #1;
            checks++;
            if (haddr_1 !== a0 || haddr_2 !== mA2 || hwdata_1 !== mW1 || hwrite_reg !== 1'b1) begin
                errors++;
                $display("[TB] FAIL wait_hold got %h/%h/%h/%b expected %h/%h/%h/1",
                         haddr_1, haddr_2, hwdata_1, hwrite_reg, a0, mA2, mW1);
            end
        end
        a1 = a0 + 32'd4;
        hreadyin = 1'b1; haddr = a1;
        cycle();
        #1;
        checks++;
        if (haddr_1 !== a1 || haddr_2 !== a0) begin
            errors++;
            $display("[TB] FAIL wait_resume got %h/%h expected %h/%h", haddr_1, haddr_2, a1, a0);
        end
        htrans = 2'b00;
        cycle();
    endtask

    task automatic test_unmapped();
        logic [1:0] wantResp [3];
        logic       wantRdy  [3];
        logic       drvRdy   [3];
        drvRdy = '{1'b1, 1'b0, 1'b1};
        if (ERR_EN) begin
            wantResp = '{2'b01, 2'b01, 2'b00};
            wantRdy  = '{1'b0, 1'b1, 1'b1};
        end else begin
            wantResp = '{2'b00, 2'b00, 2'b00};
            wantRdy  = '{1'b1, 1'b0, 1'b1};
        end
        haddr = 32'h9000_0000; htrans = 2'b10; hreadyin = 1'b1; hwrite = 1'b0; bridge_ready = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || tempselx !== 3'b000) begin
            errors++;
            $display("[TB] FAIL unmapped_decode got %b/%b expected 0/000", valid, tempselx);
        end
        checks++;
        if (hreadyout !== 1'b0 || hresp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL unmapped_addr_phase got %b/%b expected 0/00", hreadyout, hresp);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            bridge_ready = drvRdy[i];
            haddr  = 32'h8000_0010;
            htrans = (i < 2) ? 2'b10 : 2'b00;
            #1;
            checks++;
            if (hreadyout !== wantRdy[i] || hresp !== wantResp[i]) begin
                errors++;
                $display("[TB] FAIL unmapped_resp step %0d got %b/%b expected %b/%b",
                         i, hreadyout, hresp, wantRdy[i], wantResp[i]);
            end
            checks++;
            if (valid !== expValid()) begin
                errors++;
                $display("[TB] FAIL unmapped_valid step %0d got %b expected %b", i, valid, expValid());
            end
        end
        cycle();
    endtask

    task automatic test_reset_during_error();
        haddr = 32'h7FFF_FFFF; htrans = 2'b11; hreadyin = 1'b1; bridge_ready = 1'b1;
        cycle();
        htrans = 2'b00; hresetn = 1'b1; bridge_ready = 1'b0;
        #1;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_in_err_same_cycle got %b/%b/%b expected 1/00/0", hreadyout, hresp, valid);
        end
        cycle();
        hresetn = 1'b0; bridge_ready = 1'b1;
        #1;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00 || haddr_1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_in_err_after got %b/%b/%h expected 1/00/00000000", hreadyout, hresp, haddr_1);
        end
        cycle();
        #1;
        checks++;
        if (hresp !== 2'b00) begin errors++; $display("[TB] FAIL rst_in_err_idle got %b expected 00", hresp); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       haddr = BASE - 32'd1;
                1:       haddr = BASE + 3 * SLOT - 32'd1;
                2:       haddr = BASE + 3 * SLOT;
                3:       haddr = BASE + SLOT;
                4:       haddr = BASE + 2 * SLOT - 32'd1;
                5:       haddr = 32'hFFFF_FFFC;
                6:       haddr = $urandom;
                default: haddr = BASE + ($urandom % (3 * SLOT));
            endcase
            htrans       = 2'($urandom);
            hwrite       = 1'($urandom);
            hwdata       = $urandom;
            prdata       = $urandom;
            hreadyin     = ($urandom_range(0, 3) != 0);
            bridge_ready = ($urandom_range(0, 3) != 0);
            hresetn      = ($urandom_range(0, 39) == 0);
            #1;
            checks++;
            if (valid !== expValid()) begin errors++; $display("[TB] FAIL rnd_valid addr=%h got %b expected %b", haddr, valid, expValid()); end
            checks++;
            if (tempselx !== expSel(haddr)) begin errors++; $display("[TB] FAIL rnd_sel addr=%h got %b expected %b", haddr, tempselx, expSel(haddr)); end
            checks++;
            if (hrdata !== prdata) begin errors++; $display("[TB] FAIL rnd_hrdata got %h expected %h", hrdata, prdata); end
            checks++;
            if (hreadyout !== expReady()) begin errors++; $display("[TB] FAIL rnd_hreadyout got %b expected %b", hreadyout, expReady()); end
            checks++;
            if (hresp !== expResp()) begin errors++; $display("[TB] FAIL rnd_hresp got %b expected %b", hresp, expResp()); end
            checks++;
            if (haddr_1 !== mA1 || haddr_2 !== mA2) begin errors++; $display("[TB] FAIL rnd_haddr got %h/%h expected %h/%h", haddr_1, haddr_2, mA1, mA2); end
            checks++;
            if (hwdata_1 !== mW1 || hwdata_2 !== mW2) begin errors++; $display("[TB] FAIL rnd_hwdata got %h/%h expected %h/%h", hwdata_1, hwdata_2, mW1, mW2); end
            checks++;
            if (hwrite_reg !== mR1 || hwrite_reg1 !== mR2) begin errors++; $display("[TB] FAIL rnd_hwrite got %b/%b expected %b/%b", hwrite_reg, hwrite_reg1, mR1, mR2); end
            cycle();
        end
        hresetn = 1'b0;
    endtask

    // Directed scenarios first, then the randomized sweep, then the summary.
    initial begin
        test_reset();
        test_single_write();
        test_burst_read();
        test_wait_states();
        test_unmapped();
        test_reset_during_error();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
